// File: rtl/toggle_cdc_rx_endpoint.sv
// rtl/toggle_cdc_rx_endpoint.sv - destination-domain endpoint of the toggle req/ack multi-bit CDC
module toggle_cdc_rx_endpoint #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 3,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic                          i_bclk,
   input  logic                          i_brst_n,
   input  logic                          i_req_toggle_async,
   input  logic [DATA_W-1:0]             i_req_data_async,
   output logic                          o_ack_toggle,
   output logic [DATA_W-1:0]             o_data_bclk,
   output logic                          o_valid_bclk,
   input  logic                          i_ready_bclk,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_overflow_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PENDING = 1'b1
   } state_t;

   logic [1:0]             r_rst_sync;
   logic                   w_rst_n;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sync_d;
   logic                   w_edge_det;
   logic [DATA_W-1:0]      r_mem [FIFO_DEPTH];
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [PW-1:0]          r_level;
   logic [DATA_W-1:0]      r_last;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_pop;
   logic                   w_write_ok;
   logic                   w_push;
   state_t                 r_state;
   logic                   r_ack;
   logic                   r_overflow;

   // Reset asserts asynchronously and releases two bclk edges later, cleanly in this domain
   always_ff @(posedge i_bclk or negedge i_brst_n) begin
      if (!i_brst_n) begin
         r_rst_sync <= '0;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   // Request-toggle synchronizer plus one delayed copy for edge detection
   always_ff @(posedge i_bclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_sync   <= '0;
         r_sync_d <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], i_req_toggle_async};
         r_sync_d <= r_sync[SYNC_STAGES-1];
      end
   end

   // One-cycle pulse per request toggle; the data bus itself is never synchronized
   assign w_edge_det = r_sync[SYNC_STAGES-1] ^ r_sync_d;

   // The extra pointer bit tells full from empty when the index bits match
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop      = !w_empty && i_ready_bclk;
   assign w_write_ok = !w_full || w_pop;

   // Push decode: a fresh edge in IDLE, or the held request once space appears in PENDING
   always_comb begin
      w_push = 1'b0;
      case (r_state)
         S_IDLE:    w_push = w_edge_det && w_write_ok;
         S_PENDING: w_push = w_write_ok;
         default:   w_push = 1'b0;
      endcase
   end

   // Control FSM: ack flips only together with a push; an edge while holding a request is a violation
   always_ff @(posedge i_bclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= S_IDLE;
         r_ack      <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_ack <= ~r_ack;
         end
         case (r_state)
            S_IDLE: begin
               if (w_edge_det && !w_write_ok) begin
                  r_state <= S_PENDING;
               end
            end
            S_PENDING: begin
               if (w_write_ok) begin
                  r_state <= S_IDLE;
               end
               if (w_edge_det) begin
                  r_overflow <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Circular buffer; r_last keeps the most recently popped word so the output holds when empty
   always_ff @(posedge i_bclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_last   <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_req_data_async;
            r_wr_ptr                <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_last   <= r_mem[r_rd_ptr[AW-1:0]];
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + PW'(1);
            2'b01:   r_level <= r_level - PW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_ack_toggle   = r_ack;
   assign o_overflow_err = r_overflow;
   assign o_valid_bclk   = !w_empty;
   assign o_fifo_level   = r_level;
   assign o_data_bclk    = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_toggle_cdc_rx_endpoint.sv
// tb/tb_toggle_cdc_rx_endpoint.sv - bench for toggle_cdc_rx_endpoint
module tb_toggle_cdc_rx_endpoint;

   logic       clk = 1'b0;
   logic       brst_n;
   logic       req;
   logic [7:0] rdata;
   logic       ack;
   logic [7:0] dout;
   logic       valid;
   logic       ready;
   logic [1:0] level;
   logic       ovf;

   always #5 clk = ~clk;

   toggle_cdc_rx_endpoint #(
      .DATA_W(8),
      .SYNC_STAGES(3),
      .FIFO_DEPTH(2)
   ) dut (
      .i_bclk(clk),
      .i_brst_n(brst_n),
      .i_req_toggle_async(req),
      .i_req_data_async(rdata),
      .o_ack_toggle(ack),
      .o_data_bclk(dout),
      .o_valid_bclk(valid),
      .i_ready_bclk(ready),
      .o_fifo_level(level),
      .o_overflow_err(ovf)
   );

   typedef struct {
      logic [7:0] data;
      int         exp_lat;
      logic [1:0] exp_level;
   } vec_t;

   vec_t       vecs[5];
   logic [7:0] sbq[$];
   int         errors    = 0;
   int         checks    = 0;
   int         ack_flips = 0;
   int         n_rx      = 0;
   logic       exp_ack   = 1'b0;
   logic       ack_prev  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      logic [7:0] w;
      @(negedge clk);
      if (valid === 1'b1 && ready === 1'b1) begin
         n_rx++;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", dout);
         end else begin
            w = sbq.pop_front();
            chk("rx_data", 32'(dout), 32'(w));
         end
      end
      if (ack !== ack_prev) begin
         ack_flips++;
         ack_prev = ack;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic toggle(input logic [7:0] d, input bit expect_push);
      rdata = d;
      req   = ~req;
      if (expect_push) sbq.push_back(d);
   endtask

   task automatic wait_ack(input int budget, input bit rnd);
      int n = 0;
      while (ack !== exp_ack && n < budget) begin
         if (rnd) ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      chk("ack_wait", 32'(ack), 32'(exp_ack));
   endtask

   task automatic send(input logic [7:0] d);
      toggle(d, 1'b1);
      exp_ack = ~exp_ack;
      wait_ack(20, 1'b0);
   endtask

   task automatic one_transfer(input vec_t v);
      ready = 1'b1;
      toggle(v.data, 1'b1);
      ticks(v.exp_lat - 1);
      chk("lat_valid_early", 32'(valid), 32'(0));
      chk("lat_ack_early", 32'(ack), 32'(exp_ack));
      tick();
      exp_ack = ~exp_ack;
      chk("lat_valid", 32'(valid), 32'(1));
      chk("lat_data", 32'(dout), 32'(v.data));
      chk("lat_ack", 32'(ack), 32'(exp_ack));
      chk("lat_level", 32'(level), 32'(v.exp_level));
      tick();
      chk("post_valid", 32'(valid), 32'(0));
      chk("post_level", 32'(level), 32'(0));
   endtask

   initial begin
      int rx0;
      int n;
      logic [7:0] d;

      vecs[0] = '{8'hA5, 4, 2'd1};
      vecs[1] = '{8'h3C, 4, 2'd1};
      vecs[2] = '{8'hFF, 4, 2'd1};
      vecs[3] = '{8'h00, 4, 2'd1};
      vecs[4] = '{8'h81, 4, 2'd1};

      brst_n = 1'b0;
      req    = 1'b0;
      rdata  = 8'h00;
      ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack), 32'(0));
      chk("rst_valid", 32'(valid), 32'(0));
      chk("rst_data", 32'(dout), 32'(0));
      chk("rst_level", 32'(level), 32'(0));
      chk("rst_ovf", 32'(ovf), 32'(0));
      brst_n = 1'b1;
      ticks(4);

      for (int i = 0; i < 5; i++) begin
         one_transfer(vecs[i]);
      end

      ready = 1'b0;
      send(8'h11);
      send(8'h22);
      chk("bp_level_full", 32'(level), 32'(2));
      toggle(8'h33, 1'b1);
      ticks(8);
      chk("bp_ack_held", 32'(ack), 32'(exp_ack));
      chk("bp_level_held", 32'(level), 32'(2));
      chk("bp_ovf", 32'(ovf), 32'(0));
      ready = 1'b1;
      tick();
      exp_ack = ~exp_ack;
      chk("bp_ack_release", 32'(ack), 32'(exp_ack));
      chk("bp_level_swap", 32'(level), 32'(2));
      ticks(2);
      chk("bp_drained_level", 32'(level), 32'(0));
      chk("bp_drained_q", 32'(sbq.size()), 32'(0));

      ready = 1'b0;
      send(8'h44);
      send(8'h55);
      chk("fp_level_full", 32'(level), 32'(2));
      toggle(8'h66, 1'b1);
      ticks(3);
      chk("fp_ack_early", 32'(ack), 32'(exp_ack));
      ready = 1'b1;
      tick();
      exp_ack = ~exp_ack;
      chk("fp_ack_same_edge", 32'(ack), 32'(exp_ack));
      chk("fp_level", 32'(level), 32'(2));
      ticks(2);
      chk("fp_drained_level", 32'(level), 32'(0));
      chk("fp_drained_q", 32'(sbq.size()), 32'(0));

      ready = 1'b0;
      send(8'h71);
      send(8'h72);
      toggle(8'h73, 1'b1);
      ticks(6);
      chk("ov_ack_held", 32'(ack), 32'(exp_ack));
      chk("ov_ovf_before", 32'(ovf), 32'(0));
      toggle(8'h73, 1'b0);
      ticks(5);
      chk("ov_ovf_set", 32'(ovf), 32'(1));
      chk("ov_ack_still_held", 32'(ack), 32'(exp_ack));
      ready = 1'b1;
      tick();
      exp_ack = ~exp_ack;
      chk("ov_ack_release", 32'(ack), 32'(exp_ack));
      ticks(6);
      chk("ov_level", 32'(level), 32'(0));
      chk("ov_valid", 32'(valid), 32'(0));
      chk("ov_sticky", 32'(ovf), 32'(1));
      chk("ov_q", 32'(sbq.size()), 32'(0));
      chk("ov_ack_final", 32'(ack), 32'(exp_ack));

      ready = 1'b0;
      send(8'h81);
      send(8'h82);
      toggle(8'h83, 1'b1);
      ticks(6);
      chk("mr_level_pre", 32'(level), 32'(2));
      brst_n = 1'b0;
      #1;
      chk("mr_ack", 32'(ack), 32'(0));
      chk("mr_valid", 32'(valid), 32'(0));
      chk("mr_level", 32'(level), 32'(0));
      chk("mr_ovf", 32'(ovf), 32'(0));
      chk("mr_data", 32'(dout), 32'(0));
      req   = 1'b0;
      rdata = 8'h00;
      sbq.delete();
      exp_ack  = 1'b0;
      ack_prev = 1'b0;
      ticks(3);
      brst_n = 1'b1;
      ticks(4);
      chk("mr_ack_after", 32'(ack), 32'(0));
      one_transfer('{8'h5A, 4, 2'd1});

      ack_flips = 0;
      rx0 = n_rx;
      for (int i = 0; i < 50; i++) begin
         d = 8'($urandom);
         toggle(d, 1'b1);
         exp_ack = ~exp_ack;
         wait_ack(100, 1'b1);
      end
      ready = 1'b1;
      n = 0;
      while (sbq.size() > 0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      chk("st_rx_count", 32'(n_rx - rx0), 32'(50));
      chk("st_ack_flips", 32'(ack_flips), 32'(50));
      chk("st_ovf", 32'(ovf), 32'(0));
      chk("st_q_empty", 32'(sbq.size()), 32'(0));
      chk("st_level", 32'(level), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/toggle_cdc_rx_endpoint.md
Name: toggle_cdc_rx_endpoint

Overview:
Receive-side endpoint of the team's toggle-request / toggle-acknowledge multi-bit CDC protocol, running entirely in the destination clock domain.
- Synchronizes an asynchronous request toggle and detects each edge.
- Captures the quasi-static data bus that the sender holds stable until acknowledged, and buffers it in a small FIFO.
- Presents the buffered words on a valid/ready interface and returns an acknowledge toggle to the sender.
- Pairs with a source-domain transmitter that owns the data register and the request toggle.

Parameters:
DATA_W, 8, width of the transferred word
SYNC_STAGES, 3, flops in the request-toggle synchronizer (legal 2..4)
FIFO_DEPTH, 2, output buffer entries (power of 2, >=2)

Ports:
bclk  in  1  destination clock; only clock in the block
brst_n  in  1  asynchronous active-low reset
req_toggle_async  in  1  request toggle from the source domain; each change = one new word
req_data_async  in  DATA_W  source data bus; sender holds it stable from its toggle until it sees ack_toggle change
ack_toggle  out  1  acknowledge toggle back to the source; flips once per accepted word
data_bclk  out  DATA_W  FIFO head word
valid_bclk  out  1  FIFO non-empty
ready_bclk  in  1  downstream accept; pop on valid_bclk && ready_bclk
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
overflow_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release on bclk): synchronizer chain, sync_d, ack_toggle, FIFO pointers, fifo_level, valid_bclk, data_bclk and overflow_err all 0; FSM = IDLE. The sender must be reset in the same window; a mid-transfer reset drops buffered words and any pending request.
- Synchronizer: sync[0] samples req_toggle_async; the word shifts one stage per bclk. sync_d is a registered copy of sync[SYNC_STAGES-1]. edge_det = sync[SYNC_STAGES-1] ^ sync_d, combinational, high for exactly one cycle per toggle.
- req_data_async is never synchronized. It is sampled only in a write cycle, where the protocol guarantees it is stable.
- write_ok = !full || pop (push into a full FIFO is allowed when a pop occurs in the same cycle).
- FSM:
  - IDLE:
    - edge_det && write_ok -> push req_data_async; flip ack_toggle; stay IDLE.
    - edge_det && !write_ok -> PENDING.
  - PENDING:
    - write_ok -> push req_data_async; flip ack_toggle; go to IDLE.
    - Otherwise stay PENDING; ack_toggle is withheld, which back-pressures the sender.
    - edge_det while PENDING -> set overflow_err (sticky until reset); discard that edge.
- Latency: toggle first sampled at bclk edge 1 -> edge_det high after edge SYNC_STAGES -> push, ack flip and valid_bclk high after edge SYNC_STAGES+1 (edge 4 at default). The ack flip and the push occur on the same edge.
- FIFO:
  - Circular buffer with wrap-around read and write pointers; one extra pointer bit distinguishes full from empty.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pop when empty is impossible because valid_bclk = 0.
  - data_bclk = mem[rd_ptr]. It is stable while valid_bclk && !ready_bclk, and holds its last value when empty.
- At most one ack flip per cycle. ack_toggle never flips without a matching push.
- Word ordering is preserved; no word is duplicated or dropped except the overflow_err edge.

Test Plan:
- Single transfer: after reset, set req_data_async=8'hA5 and toggle req 0->1, ready_bclk=1 -> valid_bclk high exactly after bclk edge 4 with data_bclk=8'hA5; ack_toggle 0->1 on the same edge; valid_bclk drops the next cycle; fifo_level returns to 0.
- Back-pressure fill: ready_bclk=0, send 8'h11 and 8'h22 (each toggle issued after the previous ack) -> fifo_level=2; send 8'h33 -> FSM enters PENDING and ack_toggle does not flip; raise ready_bclk -> 8'h11 popped, 8'h33 pushed in the same cycle, ack flips; output order 11, 22, 33.
- Full plus simultaneous pop: FIFO full, ready_bclk=1 in the same cycle edge_det rises -> push accepted without entering PENDING; fifo_level stays 2.
- Protocol violation: while PENDING, toggle req again without waiting for ack -> overflow_err=1 and stays 1; the extra word is never presented; clears only on brst_n.
- Reset mid-operation: assert brst_n low with fifo_level=2 and FSM in PENDING -> all outputs 0 immediately, no ack flip; after release, a fresh transfer of 8'h5A completes with the nominal 4-edge latency.
- Throughput stress: 50 random words with random ready_bclk, each sender toggle issued after the ack is observed -> all 50 received in order, ack_toggle flip count = 50, overflow_err=0.
